// File: rtl/i2c_slave_if.sv
// i2c_slave_if: bus-side and byte-level user signals of the I2C target
// slave modport: target view (bus levels and user controls in, line drives and status out)
// master modport: bus/user side view, the mirror of slave
interface i2c_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       scl_out;
  logic       sda_out;
  logic [7:0] rx_dat;
  logic       rx_vld;
  logic       rx_nack;
  logic [7:0] tx_dat;
  logic       tx_vld;
  logic       tx_req;
  logic       sel;
  logic       rnw;
  logic       sta;
  logic       sto;
  modport slave (
    input  scl_in, sda_in, rx_nack, tx_dat, tx_vld,
    output scl_out, sda_out, rx_dat, rx_vld, tx_req, sel, rnw, sta, sto
  );
  modport master (
    output scl_in, sda_in, rx_nack, tx_dat, tx_vld,
    input  scl_out, sda_out, rx_dat, rx_vld, tx_req, sel, rnw, sta, sto
  );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with input filtering, START/STOP detection, 7-bit address match, byte rx/tx
// Ports: clk, rst (sync, active-high), bus (i2c_slave_if.slave):
//   scl_in/sda_in bus levels, scl_out/sda_out open-drain drives (1 = release),
//   rx_dat/rx_vld/rx_nack write-byte interface, tx_dat/tx_vld/tx_req read-byte interface,
//   sel/rnw selection status, sta/sto START and STOP pulses.
// Option: define I2C_SLAVE_STRETCH_EN to hold SCL low at each read byte until tx_vld.
module i2c_slave #(
  parameter logic [6:0] I2C_ADDR = 7'h2a,
  parameter int         FILT_LEN = 3
) (
  input logic        clk,
  input logic        rst,
  i2c_slave_if.slave bus
);
  localparam int CW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
  typedef enum logic [2:0] {IDLE, ADDR, AACK, WRX, WACK, RTX, RACK, WSTOP} state_t;
  // index 0 = SCL, index 1 = SDA
  logic [1:0]    raw, s1_q, s2_q, f_q, fp_q;
  logic [CW-1:0] cnt_q [2];
  logic scl_rise, scl_fall, start, stop, sda_f;
  assign raw = {bus.sda_in, bus.scl_in};
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
      f_q  <= 2'b11;
      fp_q <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      fp_q <= f_q;
      // a new level is accepted only after FILT_LEN consecutive equal samples
      for (int i = 0; i < 2; i++)
        if (s2_q[i] == f_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
          f_q[i]   <= s2_q[i];
          cnt_q[i] <= '0;
        end else cnt_q[i] <= cnt_q[i] + CW'(1);
    end
  end
  assign sda_f    = f_q[1];
  assign scl_rise = f_q[0] & ~fp_q[0];
  assign scl_fall = ~f_q[0] & fp_q[0];
  assign start    = f_q[0] & fp_q[0] & ~f_q[1] & fp_q[1];
  assign stop     = f_q[0] & fp_q[0] & f_q[1] & ~fp_q[1];
  state_t     state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sr_q, sr_d, rx_dat_q, rx_dat_d, byte_in;
  logic sda_q, sda_d, sel_q, sel_d, rnw_q, rnw_d, ack_q, ack_d, ph_q, ph_d;
  logic rx_vld_q, rx_vld_d, tx_req_q, tx_req_d, sta_q, sta_d, sto_q, sto_d, ld;
`ifdef I2C_SLAVE_STRETCH_EN
  logic scl_q, scl_d, str_q, str_d;
`endif
  assign byte_in = {sr_q[6:0], sda_f};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bcnt_q   <= '0;
      sr_q     <= '0;
      sda_q    <= 1'b1;
      sel_q    <= 1'b0;
      rnw_q    <= 1'b0;
      ack_q    <= 1'b0;
      ph_q     <= 1'b0;
      rx_dat_q <= '0;
      rx_vld_q <= 1'b0;
      tx_req_q <= 1'b0;
      sta_q    <= 1'b0;
      sto_q    <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_q    <= 1'b1;
      str_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      sr_q     <= sr_d;
      sda_q    <= sda_d;
      sel_q    <= sel_d;
      rnw_q    <= rnw_d;
      ack_q    <= ack_d;
      ph_q     <= ph_d;
      rx_dat_q <= rx_dat_d;
      rx_vld_q <= rx_vld_d;
      tx_req_q <= tx_req_d;
      sta_q    <= sta_d;
      sto_q    <= sto_d;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_q    <= scl_d;
      str_q    <= str_d;
`endif
    end
  end
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    sr_d     = sr_q;
    sda_d    = sda_q;
    sel_d    = sel_q;
    rnw_d    = rnw_q;
    ack_d    = ack_q;
    ph_d     = ph_q;
    rx_dat_d = rx_dat_q;
    rx_vld_d = 1'b0;
    tx_req_d = 1'b0;
    sta_d    = 1'b0;
    sto_d    = 1'b0;
    ld       = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
    scl_d    = scl_q;
    str_d    = str_q;
`endif
    if (start) begin
      state_d = ADDR;
      bcnt_d  = 3'd7;
      sta_d   = 1'b1;
      sel_d   = 1'b0;
      sda_d   = 1'b1;
      ph_d    = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_d   = 1'b1;
      str_d   = 1'b0;
`endif
    end else if (stop) begin
      state_d = IDLE;
      sto_d   = 1'b1;
      sel_d   = 1'b0;
      sda_d   = 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_d   = 1'b1;
      str_d   = 1'b0;
`endif
    end else
      case (state_q)
        ADDR: if (scl_rise) begin
          sr_d   = byte_in;
          bcnt_d = bcnt_q - 3'd1;
          if (bcnt_q == 3'd0) begin
            state_d  = byte_in[7:1] == I2C_ADDR ? AACK : WSTOP;
            rnw_d    = byte_in[7:1] == I2C_ADDR ? byte_in[0] : rnw_q;
            tx_req_d = byte_in[7:1] == I2C_ADDR && byte_in[0];
            ph_d     = 1'b0;
          end
        end
        // first fall drives ACK, second fall ends the ACK bit
        AACK: if (scl_fall) begin
          ph_d = ~ph_q;
          if (!ph_q) begin
            sda_d = 1'b0;
            sel_d = 1'b1;
          end else begin
            bcnt_d  = 3'd7;
            state_d = rnw_q ? RTX : WRX;
            sda_d   = 1'b1;
            ld      = rnw_q;
          end
        end
        WRX: if (scl_rise) begin
          sr_d   = byte_in;
          bcnt_d = bcnt_q - 3'd1;
          if (bcnt_q == 3'd0) begin
            rx_dat_d = byte_in;
            rx_vld_d = 1'b1;
            ack_d    = ~bus.rx_nack;
            state_d  = WACK;
            ph_d     = 1'b0;
          end
        end
        WACK: if (scl_fall) begin
          ph_d  = ~ph_q;
          sda_d = ph_q ? 1'b1 : ~ack_q;
          if (ph_q) begin
            bcnt_d  = 3'd7;
            state_d = ack_q ? WRX : WSTOP;
          end
        end
        RTX: begin
`ifdef I2C_SLAVE_STRETCH_EN
          if (str_q) begin
            if (bus.tx_vld) begin
              sr_d  = bus.tx_dat;
              sda_d = bus.tx_dat[7];
              scl_d = 1'b1;
              str_d = 1'b0;
            end
          end else
`endif
          if (scl_fall) begin
            sda_d   = bcnt_q == 3'd0 ? 1'b1 : sr_q[6];
            sr_d    = {sr_q[6:0], 1'b0};
            bcnt_d  = bcnt_q - 3'd1;
            state_d = bcnt_q == 3'd0 ? RACK : RTX;
          end
        end
        RACK:
          if (scl_rise) begin
            state_d  = sda_f ? WSTOP : RACK;
            tx_req_d = ~sda_f;
          end else if (scl_fall) begin
            bcnt_d  = 3'd7;
            state_d = RTX;
            ld      = 1'b1;
          end
        default: ;
      endcase
    if (ld) begin
`ifdef I2C_SLAVE_STRETCH_EN
      sda_d = 1'b1;
      scl_d = 1'b0;
      str_d = 1'b1;
`else
      sr_d  = bus.tx_dat;
      sda_d = bus.tx_dat[7];
`endif
    end
  end
`ifdef I2C_SLAVE_STRETCH_EN
  assign bus.scl_out = scl_q;
`else
  assign bus.scl_out = 1'b1;
`endif
  assign bus.sda_out = sda_q;
  assign bus.rx_dat  = rx_dat_q;
  assign bus.rx_vld  = rx_vld_q;
  assign bus.tx_req  = tx_req_q;
  assign bus.sel     = sel_q;
  assign bus.rnw     = rnw_q;
  assign bus.sta     = sta_q;
  assign bus.sto     = sto_q;
endmodule
